// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: op codes, issue FSM states and op classification.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_LD  = 3'b110,
    OP_ST  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } issue_state_e;

  // Only ADD and SUB consume carry_in and update the carry flag.
  function automatic logic is_arith(alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x SIZE register file: two combinational read ports, one synchronous write
// port shared by ALU writeback and external preload (writeback has priority).
module alu_regfile
  import alu_pkg::*;
#(
  parameter  int SIZE  = 8,
  parameter  int NREGS = 4,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RW-1:0]   ra_addr_i,
  input  logic [RW-1:0]   rb_addr_i,
  output logic [SIZE-1:0] ra_data_o,
  output logic [SIZE-1:0] rb_data_o,
  input  logic            wb_en_i,
  input  logic [RW-1:0]   wb_addr_i,
  input  logic [SIZE-1:0] wb_data_i,
  input  logic            pl_en_i,
  input  logic [RW-1:0]   pl_addr_i,
  input  logic [SIZE-1:0] pl_data_i
);

  logic [SIZE-1:0] mem_q [NREGS];
  logic            wr_en;
  logic [RW-1:0]   wr_addr;
  logic [SIZE-1:0] wr_data;

  // NOTE: every signal gets a default before the if-chain so no path leaves it unassigned (no latch).
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (wb_en_i) begin
      wr_en   = 1'b1;
      wr_addr = wb_addr_i;
      wr_data = wb_data_i;
    end else if (pl_en_i) begin
      wr_en   = 1'b1;
      wr_addr = pl_addr_i;
      wr_data = pl_data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: this array is architectural state that must read as zero after reset, so it is cleared
  // explicitly; a large RAM macro would not be reset this way.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign ra_data_o = mem_q[ra_addr_i];
  assign rb_data_o = mem_q[rb_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing stage in front of a combinational ALU: IDLE -> EXEC -> WB per instruction.
// Optional zero_flag output is enabled by defining ALU_ISSUE_ZERO_FLAG_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter  int SIZE  = 8,
  parameter  int NREGS = 4,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [2:0]      instr_op,
  input  logic [RW-1:0]   instr_rd,
  input  logic [RW-1:0]   instr_rs,
  input  logic            instr_cin_en,
  output logic            alu_ce,
  output logic [2:0]      alu_op,
  output logic [SIZE-1:0] alu_left,
  output logic [SIZE-1:0] alu_right,
  output logic            alu_cin,
  input  logic [SIZE-1:0] alu_result,
  input  logic            alu_cout,
  output logic            done,
  output logic [SIZE-1:0] wb_data,
  output logic            st_valid,
  output logic [SIZE-1:0] st_data,
  output logic            carry_flag,
  input  logic            preload_en,
  input  logic [RW-1:0]   preload_addr,
  input  logic [SIZE-1:0] preload_data
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  ,
  output logic            zero_flag
`endif
);

  issue_state_e    state_q, state_d;
  alu_op_e         op_q, op_d, instr_op_e;
  logic [RW-1:0]   rd_q, rd_d;
  logic [SIZE-1:0] left_q, left_d, right_q, right_d;
  logic            cin_q, cin_d;
  logic [SIZE-1:0] wb_data_q, wb_data_d, st_data_q, st_data_d;
  logic            carry_q, carry_d;
  logic [SIZE-1:0] rd_val, rs_val;
  logic            accept, in_exec, rf_wb_en;

  assign instr_op_e = alu_op_e'(instr_op);
  assign accept     = instr_valid && (state_q == S_IDLE);
  assign in_exec    = (state_q == S_EXEC);
  assign rf_wb_en   = in_exec && (op_q != OP_ST);

  alu_regfile #(.SIZE(SIZE), .NREGS(NREGS)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_addr_i (instr_rd),
    .rb_addr_i (instr_rs),
    .ra_data_o (rd_val),
    .rb_data_o (rs_val),
    .wb_en_i   (rf_wb_en),
    .wb_addr_i (rd_q),
    .wb_data_i (alu_result),
    .pl_en_i   (preload_en),
    .pl_addr_i (preload_addr),
    .pl_data_i (preload_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operands are sampled at accept; ALU result and flags are captured on the EXEC exit edge.
  always_comb begin
    op_d      = op_q;
    rd_d      = rd_q;
    left_d    = left_q;
    right_d   = right_q;
    cin_d     = cin_q;
    wb_data_d = wb_data_q;
    st_data_d = st_data_q;
    carry_d   = carry_q;
    if (accept) begin
      op_d    = instr_op_e;
      rd_d    = instr_rd;
      left_d  = rd_val;
      right_d = rs_val;
      cin_d   = is_arith(instr_op_e) && instr_cin_en && carry_q;
    end
    if (in_exec) begin
      wb_data_d = alu_result;
      if (op_q == OP_ST)  st_data_d = alu_result;
      if (is_arith(op_q)) carry_d   = alu_cout;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= OP_ADD;
      rd_q      <= '0;
      left_q    <= '0;
      right_q   <= '0;
      cin_q     <= 1'b0;
      wb_data_q <= '0;
      st_data_q <= '0;
      carry_q   <= 1'b0;
    end else begin
      op_q      <= op_d;
      rd_q      <= rd_d;
      left_q    <= left_d;
      right_q   <= right_d;
      cin_q     <= cin_d;
      wb_data_q <= wb_data_d;
      st_data_q <= st_data_d;
      carry_q   <= carry_d;
    end
  end

`ifdef ALU_ISSUE_ZERO_FLAG_EN
  logic zero_q, zero_d;

  always_comb begin
    zero_d = zero_q;
    if (in_exec && (op_q != OP_ST)) zero_d = (alu_result == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) zero_q <= 1'b0;
    else        zero_q <= zero_d;
  end

  assign zero_flag = zero_q;
`endif

  assign instr_ready = (state_q == S_IDLE);
  assign alu_ce      = in_exec;
  assign done        = (state_q == S_WB);
  assign st_valid    = done && (op_q == OP_ST);
  assign alu_op      = op_q;
  assign alu_left    = left_q;
  assign alu_right   = right_q;
  assign alu_cin     = cin_q;
  assign wb_data     = wb_data_q;
  assign st_data     = st_data_q;
  assign carry_flag  = carry_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequencing stage directly upstream of the ALU. It accepts one instruction at a time over a valid/ready handshake and reads operands from a small register file. It then drives the ALU's CE/OP_CODE/operand/carry inputs for exactly one cycle, captures op_out/carry_out, and writes back to the register file and carry flag. The block owns architectural state (registers, carry). The ALU remains purely combinational.

Parameters:
SIZE, 8, data width; must match the ALU's SIZE
NREGS, 4, register-file depth; power of 2, at least 2
RW, $clog2(NREGS), register index width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
instr_valid  in  1  instruction present
instr_ready  out  1  block can accept an instruction
instr_op  in  3  ALU op code: ADD=000 SUB=001 AND=010 OR=011 XOR=100 NOT=101 LD=110 ST=111
instr_rd  in  RW  destination register, also the left-operand source
instr_rs  in  RW  right-operand source register
instr_cin_en  in  1  ADD/SUB only: 1 = use carry_flag as carry_in, 0 = use 0
alu_ce  out  1  to ALU CE
alu_op  out  3  to ALU OP_CODE
alu_left  out  SIZE  to ALU left_operand
alu_right  out  SIZE  to ALU right_operand
alu_cin  out  1  to ALU carry_in
alu_result  in  SIZE  from ALU op_out
alu_cout  in  1  from ALU carry_out
done  out  1  one-cycle pulse: instruction retired
wb_data  out  SIZE  retired result; valid while done=1
st_valid  out  1  one-cycle pulse on a retired ST
st_data  out  SIZE  stored value; valid while st_valid=1
carry_flag  out  1  architectural carry
preload_en  in  1  external register write
preload_addr  in  RW  external write index
preload_data  in  SIZE  external write data

Behaviour:
- Reset (rst_n=0 at a clk edge): the following all clear to 0.
  - State goes to IDLE.
  - All registers, carry_flag, alu_op/alu_left/alu_right/alu_cin, wb_data and st_data become 0.
  - done, st_valid and alu_ce become 0.
  - Reset wins over every other event, including mid-EXEC or WB; the in-flight instruction is dropped with no writeback.
- FSM states: IDLE, EXEC, WB.
  - instr_ready=1 only in IDLE.
  - Accept happens when instr_valid && instr_ready. On accept, latch:
    - alu_op = instr_op
    - alu_left = reg[rd]
    - alu_right = reg[rs]
    - alu_cin = (op is ADD or SUB) && instr_cin_en && carry_flag
    - Then go to EXEC.
  - EXEC (exactly 1 cycle): alu_ce=1. At the edge leaving EXEC, capture alu_result into wb_data.
    - Ops 000–110: reg[rd] <= alu_result.
    - ADD/SUB: carry_flag <= alu_cout. All other ops leave carry_flag unchanged.
    - ST: no register write; st_data <= alu_result.
    - Go to WB.
  - WB (1 cycle): done=1; st_valid=1 if the op was ST. Go to IDLE.
  - alu_ce=0 in IDLE and WB. alu_op and the operand outputs hold their last values until the next accept.
- Latency and throughput: accept at edge T, alu_ce high during cycle T+1, done high during cycle T+2. Throughput is 1 instruction per 3 cycles.
- Operand read happens at accept. A preload in the same cycle is not visible to that instruction.
- Preload may occur in any state. If preload and writeback target the same register on the same edge, writeback wins.
- No arithmetic is performed in this block. Widths pass straight through to the ALU.

Optional Feature:
ALU_ISSUE_ZERO_FLAG_EN: when defined, the block adds output zero_flag (1 bit, reset 0).
- zero_flag <= (alu_result == 0) at the edge leaving EXEC, for every op except ST.
- ST leaves zero_flag unchanged.
When the macro is undefined, the port and its logic are absent.

Decomposition:
- Shared package alu_pkg holds:
  - op-code localparams or enum (ADD..ST)
  - issue state enum (IDLE, EXEC, WB)
  - helper function is_arith(op)
- Sub-module alu_regfile: NREGS x SIZE, two combinational read ports, one synchronous write port with a priority-muxed preload/writeback input, synchronous clear on rst_n.

Test Plan:
1. Preload r0=0x0F, r1=0x01; ADD rd0 rs1 cin_en=0 -> EXEC: alu_ce=1, op=000, left=0x0F, right=0x01; WB: done=1, wb_data=0x10, carry_flag=0, r0=0x10.
2. r0=0xFF, r1=0x01, ADD -> wb 0x00, carry 1. Then r2=0x00, r3=0x00, ADD rd2 rs3 cin_en=1 -> alu_cin=1, wb 0x01, carry 0.
3. r0=0x05, r1=0x07, SUB cin_en=0 -> wb 0xFE, carry 1. Then AND r0,r1 -> carry stays 1.
4. r2=0xAA, ST rd2 -> st_valid=1, st_data=0xAA, registers unchanged. LD rd3 rs1 (r1=0x07) -> r3=0x07, st_valid=0.
5. instr_valid held high with 3 queued instructions -> instr_ready high 1 cycle in 3, accepts spaced exactly 3 cycles, done pulses 2 cycles after each accept.
6. rst_n=0 during EXEC of ADD (r0=0x0F) -> next cycle IDLE, done=0, all registers and carry_flag 0. Also preload r1 on the same edge as writeback to r1 -> writeback value kept.
